// File: rtl/lsu_ctrl.sv
// Memory-stage load/store controller: one outstanding data-memory transaction,
// store lane formatting, load extraction/extension and alignment fault detection.
module lsu_ctrl (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        mem_v_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] ld_result_o,
  output logic        done_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic        fault_q;
  logic [31:0] ld_result_q;

  logic        accept;
  logic        fault_d;
  logic [31:0] shifted;
  logic [31:0] load_fmt;
  logic [31:0] wdata;
  logic [3:0]  wmask;

  assign accept = valid_i & (state_q == IDLE);

  // Misalignment and illegal width codes are resolved from the raw request at accept time.
  always_comb begin
    fault_d = 1'b1;
    case (funct3_i)
      3'b000:  fault_d = 1'b0;
      3'b001:  fault_d = addr_i[0];
      3'b010:  fault_d = |addr_i[1:0];
      3'b100:  fault_d = we_i;
      3'b101:  fault_d = we_i | addr_i[0];
      default: fault_d = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = fault_d ? DONE : REQ;
      REQ:     if (mem_ready_i) state_d = we_q ? DONE : WAIT;
      WAIT:    if (mem_rvalid_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wmask = 4'b0000;
    wdata = sdata_q;
    if (we_q) begin
      case (funct3_q[1:0])
        2'b00: begin
          wmask = 4'b0001 << addr_q[1:0];
          wdata = {4{sdata_q[7:0]}};
        end
        2'b01: begin
          wmask = 4'b0011 << addr_q[1:0];
          wdata = {2{sdata_q[15:0]}};
        end
        default: wmask = 4'b1111;
      endcase
    end
  end

  // The addressed byte/halfword is moved to bit 0 before extension.
  always_comb begin
    shifted  = mem_rdata_i >> {addr_q[1:0], 3'b000};
    load_fmt = shifted;
    case (funct3_q)
      3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_fmt = {24'h000000, shifted[7:0]};
      3'b101:  load_fmt = {16'h0000, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      sdata_q     <= 32'h0;
      fault_q     <= 1'b0;
      ld_result_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= we_i;
        funct3_q <= funct3_i;
        addr_q   <= addr_i;
        sdata_q  <= store_data_i;
        fault_q  <= fault_d;
      end
      if ((state_q == WAIT) && mem_rvalid_i) ld_result_q <= load_fmt;
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign mem_v_o     = (state_q == REQ);
  assign mem_we_o    = (state_q == REQ) & we_q;
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_wdata_o = wdata;
  assign mem_wmask_o = wmask;
  assign ld_result_o = ld_result_q;
  assign done_o      = (state_q == DONE);
  assign fault_o     = (state_q == DONE) & fault_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized ops
// compared against a byte-level reference model of the access rules.
module tb_lsu_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic        ready_o;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic        mem_v_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] ld_result_o;
  logic        done_o;
  logic        fault_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] expLd = 32'h0;

  lsu_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .we_i(we_i), .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i),
    .mem_v_o(mem_v_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .ld_result_o(ld_result_o),
    .done_o(done_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int accessBytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit modelFault(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || ((int'(a[1:0]) % accessBytes(f3)) != 0);
  endfunction

  function automatic logic [3:0] modelMask(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m = 4'b0;
    for (int k = 0; k < accessBytes(f3); k++) m[int'(a[1:0]) + k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % accessBytes(f3)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
    longint v = 0;
    int size = accessBytes(f3);
    int off = int'(a[1:0]);
    for (int k = 0; k < size; k++) v += longint'(rd[8*(off + k) +: 8]) << (8*k);
    if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size - 1))) v -= longint'(1) << (8*size);
    return v[31:0];
  endfunction

  // One complete operation; rdly stalls mem_ready_i, vdly stalls mem_rvalid_i,
  // junk drives spurious read data while still in the request phase.
  task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] sd, input logic [31:0] rd,
                               input int rdly, input int vdly, input bit junk);
    bit flt = modelFault(we, f3, a);
    valid_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; store_data_i = sd;
    checkOutput("ready_idle", ready_o, 1);
    step();
    valid_i = 1'b0; we_i = ~we; funct3_i = 3'($urandom); addr_i = $urandom; store_data_i = $urandom;
    if (flt) begin
      checkOutput("fault_done", done_o, 1);
      checkOutput("fault_flag", fault_o, 1);
      checkOutput("fault_no_req", mem_v_o, 0);
      checkOutput("fault_ld_kept", ld_result_o, expLd);
      step();
      checkOutput("fault_done_clr", done_o, 0);
      return;
    end
    for (int i = 0; i <= rdly; i++) begin
      checkOutput("req_v", mem_v_o, 1);
      checkOutput("req_we", mem_we_o, 32'(we));
      checkOutput("req_addr", mem_addr_o, {a[31:2], 2'b00});
      checkOutput("req_mask", mem_wmask_o, we ? 32'(modelMask(f3, a)) : 32'h0);
      if (we) checkOutput("req_wdata", mem_wdata_o, modelWdata(f3, sd));
      checkOutput("req_ready", ready_o, 0);
      checkOutput("req_done", done_o, 0);
      mem_ready_i = (i == rdly);
      mem_rvalid_i = junk;
      mem_rdata_i = $urandom;
      step();
    end
    mem_ready_i = 1'b0;
    mem_rvalid_i = 1'b0;
    if (!we) begin
      for (int i = 0; i <= vdly; i++) begin
        checkOutput("wait_v", mem_v_o, 0);
        checkOutput("wait_done", done_o, 0);
        checkOutput("wait_ready", ready_o, 0);
        mem_rvalid_i = (i == vdly);
        mem_rdata_i = (i == vdly) ? rd : $urandom;
        step();
      end
      mem_rvalid_i = 1'b0;
      expLd = modelLoad(f3, a, rd);
    end
    checkOutput("done", done_o, 1);
    checkOutput("done_fault", fault_o, 0);
    checkOutput("done_v", mem_v_o, 0);
    checkOutput("ld_result", ld_result_o, expLd);
    step();
    checkOutput("back_idle", ready_o, 1);
  endtask

  initial begin
    reset_i = 1'b1; valid_i = 1'b0; we_i = 1'b0; funct3_i = 3'b0; addr_i = 32'h0;
    store_data_i = 32'h0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    #3;
    checkOutput("rst_ready", ready_o, 1);
    checkOutput("rst_v", mem_v_o, 0);
    checkOutput("rst_we", mem_we_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_fault", fault_o, 0);
    checkOutput("rst_addr", mem_addr_o, 0);
    checkOutput("rst_wdata", mem_wdata_o, 0);
    checkOutput("rst_mask", mem_wmask_o, 0);
    checkOutput("rst_ld", ld_result_o, 0);
    step();
    reset_i = 1'b0;
    step();

    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
    checkOutput("lw_value", expLd, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 1'b0);
    checkOutput("lb_value", ld_result_o, 32'hFFFFFF80);
    applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 1'b0);
    checkOutput("lbu_value", ld_result_o, 32'h00000080);
    applyStimulus(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, 0, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0);
    applyStimulus(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 3, 0, 1'b1);

    // Reset while the controller waits for read data.
    applyStimulus(1'b0, 3'b101, 32'h402, 32'h0, 32'h9ABC1234, 0, 1, 1'b0);
    valid_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h500;
    step();
    valid_i = 1'b0; mem_ready_i = 1'b1;
    step();
    mem_ready_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    checkOutput("midrst_ready", ready_o, 1);
    checkOutput("midrst_v", mem_v_o, 0);
    checkOutput("midrst_addr", mem_addr_o, 0);
    checkOutput("midrst_ld", ld_result_o, 0);
    expLd = 32'h0;
    step();
    reset_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55555555;
    step();
    mem_rvalid_i = 1'b0;
    checkOutput("late_rvalid_done", done_o, 0);
    checkOutput("late_rvalid_ld", ld_result_o, 0);
    applyStimulus(1'b0, 3'b010, 32'h600, 32'h0, 32'h13579BDF, 0, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      applyStimulus(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller for the memory stage: it drives the single outstanding data-memory transaction and returns the formatted load word. It takes the effective address (the ALU result) and store data from execute. It runs a req/resp handshake with data memory and produces the sign/zero-extended `ld_result_o` that feeds the writeback load-result input. It also generates byte write masks and lane-replicated store data, and flags misaligned or illegal accesses without touching memory.

## Interface
- No parameters; all data/address widths are `rvga_word` (32 bits).
- `clk_i`  in  1  clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `valid_i`  in  1  memory op offered by execute.
- `ready_o`  out  1  op accepted when `valid_i & ready_o`.
- `we_i`  in  1  1 = store, 0 = load.
- `funct3_i`  in  3  RISC-V width code.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `addr_i`  in  32  effective byte address.
- `store_data_i`  in  32  rs2 value.
- `mem_v_o`  out  1  memory request valid.
- `mem_we_o`  out  1  request is a write.
- `mem_addr_o`  out  32  word-aligned address: `{addr[31:2], 2'b00}`.
- `mem_wdata_o`  out  32  lane-aligned store data.
- `mem_wmask_o`  out  4  byte enables.
- `mem_ready_i`  in  1  memory accepts the request this cycle.
- `mem_rvalid_i`  in  1  read data valid.
- `mem_rdata_i`  in  32  read word.
- `ld_result_o`  out  32  formatted load result (registered).
- `done_o`  out  1  one-cycle completion pulse.
- `fault_o`  out  1  valid with `done_o`: the op was misaligned or illegal.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- All request fields (`we`, `funct3`, `addr`, `store_data`) are latched on acceptance.
- IDLE
  - `ready_o` = 1.
  - On accept with a fault: go to DONE with the fault flag set. No memory request is made.
  - On accept without a fault: go to REQ.
- Fault conditions:
  - Halfword access with `addr[0]` = 1.
  - Word access with `addr[1:0]` ≠ 0.
  - Illegal `funct3`: loads 011/110/111; stores other than 000/001/010.
- REQ
  - `mem_v_o` = 1; `mem_addr_o`, `mem_we_o`, `mem_wdata_o` and `mem_wmask_o` are held stable until `mem_ready_i`.
  - On `mem_ready_i`: a store goes to DONE; a load goes to WAIT.
- WAIT
  - On `mem_rvalid_i`: register the formatted data into `ld_result_o`, then go to DONE.
  - `mem_rvalid_i` in any state other than WAIT is ignored.
- DONE
  - `done_o` = 1 and `fault_o` = the latched fault flag.
  - Next state is IDLE.
  - `ready_o` = 0 in REQ, WAIT and DONE.
- Store formatting (o = `addr[1:0]`):
  - SB: mask = `4'b0001 << o`; wdata = byte replicated to all four lanes.
  - SH: mask = `4'b0011 << o`; wdata = halfword replicated to both halves.
  - SW: mask = `4'b1111`; wdata = `store_data`.
  - For loads, `mem_wmask_o` = 0.
- Load formatting:
  - Shift: `mem_rdata_i >> (8*o)`.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- `ld_result_o` holds its value until the next successful load. It is not updated by stores or faulted ops.
- Reset asserted mid-operation:
  - Immediately drops `mem_v_o`; the transaction is abandoned.
  - A late `mem_rvalid_i` after reset is ignored, since the FSM is in IDLE.

## Timing
- Reset values:
  - State IDLE; `ready_o` = 1.
  - `mem_v_o`, `mem_we_o`, `done_o`, `fault_o` = 0.
  - `mem_addr_o`, `mem_wdata_o`, `mem_wmask_o`, `ld_result_o` = 0.
- Zero-wait memory (`mem_ready_i` = 1 in REQ, `mem_rvalid_i` the next cycle). Accept is at cycle 0.
  - Load: REQ at cycle 1, WAIT at cycle 2, `done_o` and the valid `ld_result_o` at cycle 3. The next accept is possible at cycle 4.
  - Store: `done_o` at cycle 2.
  - Fault: `done_o` at cycle 1.
- Each cycle of `mem_ready_i` = 0 extends REQ by one cycle. Each cycle without `mem_rvalid_i` extends WAIT by one cycle.
- `mem_rvalid_i` in the same cycle as the REQ handshake is not captured. Memory must return data at least one cycle after `mem_ready_i`.
- All outputs are derived from registered state or latched fields. There is no combinational path from `mem_*_i` to `mem_*_o`.

## Test plan
- LW at `0x100`, memory returns `0xDEADBEEF` one cycle after ready → `ld_result_o` = `0xDEADBEEF` with `done_o` at cycle 3; `fault_o` = 0.
- LB at `0x103` and LBU at `0x103` with rdata `0x80FF_0000`:
  - LB → `ld_result_o` = `0xFFFFFF80`.
  - LBU → `ld_result_o` = `0x00000080`.
- SH at `0x202`, store data `0x1234ABCD` → `mem_addr_o` = `0x200`, `mem_wmask_o` = `4'b1100`, `mem_wdata_o` = `0xABCDABCD`, `mem_we_o` = 1; `done_o` at cycle 2.
- LW at `0x101` → `done_o` and `fault_o` at cycle 1; `mem_v_o` never asserted; `ld_result_o` unchanged.
- Memory holds `mem_ready_i` low for 3 cycles on an SW at `0x300`:
  - Request fields stay constant and `ready_o` stays 0.
  - A spurious `mem_rvalid_i` during REQ is ignored.
  - `done_o` arrives 3 cycles late.
- `reset_i` pulsed while in WAIT → outputs return to their reset values asynchronously; a subsequent `mem_rvalid_i` is ignored; the next LW completes normally.
